// File: rtl/prog_seq_pkg.sv
// Shared definitions for the program sequencer: sizes and state encoding.
package prog_seq_pkg;

  localparam int unsigned PROG_DEPTH = 16;
  localparam int unsigned INSTR_W    = 8;
  localparam int unsigned ADDR_W     = 4;
  localparam int unsigned STATE_W    = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_HALT = 2'd3
  } seq_state_e;

endpackage

// File: rtl/prog_sequencer_tick_divider.sv
// Tick divider for the RUN clock-enable rate.
// Ports:
//   clk, n_reset : system clock, synchronous active-low reset
//   clear        : restart the count from zero this cycle
//   enable       : advance the count at the coming edge
//   tc_c         : combinational terminal count (count reaches CLK_DIV-1)
module tick_divider #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic n_reset,
  input  logic clear,
  input  logic enable,
  output logic tc_c
);

  localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] base_c;

  // A clear cycle counts as count 0, so an entry edge is itself the first tick.
  assign base_c = clear ? '0 : cnt_q;
  assign tc_c   = (base_c == CNT_W'(CLK_DIV - 1));

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      cnt_q <= '0;
    end else if (enable) begin
      cnt_q <= tc_c ? '0 : base_c + CNT_W'(1);
    end else if (clear) begin
      cnt_q <= '0;
    end
  end

endmodule

// File: rtl/prog_sequencer.sv
// Program loader and execution controller for the 4-bit CPU core.
// Owns a 16x8 program RAM, loads it over a valid/ready byte stream and
// sequences the CPU through reset, divided-rate run, halt, step and breakpoint.
// Ports:
//   clk, n_reset        : system clock, synchronous active-low reset
//   ld_valid/ld_data    : load byte stream, accepted when ld_valid && ld_ready
//   ld_ready            : loader may accept a byte (LOAD only)
//   cmd_load/run/step/halt : single-cycle command pulses (halt>load>step>run)
//   bp_en, bp_addr      : breakpoint enable and instruction address
//   cpu_addr, cpu_data  : CPU instruction fetch (combinational read)
//   cpu_n_reset         : CPU synchronous reset, active-low
//   cpu_clk_en          : CPU clock enable
//   state, loaded       : sequencer state and complete-image flag
module prog_sequencer
  import prog_seq_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic               clk,
  input  logic               n_reset,
  input  logic               ld_valid,
  input  logic [INSTR_W-1:0] ld_data,
  output logic               ld_ready,
  input  logic               cmd_load,
  input  logic               cmd_run,
  input  logic               cmd_step,
  input  logic               cmd_halt,
  input  logic               bp_en,
  input  logic [ADDR_W-1:0]  bp_addr,
  input  logic [ADDR_W-1:0]  cpu_addr,
  output logic [INSTR_W-1:0] cpu_data,
  output logic               cpu_n_reset,
  output logic               cpu_clk_en,
  output logic [STATE_W-1:0] state,
  output logic               loaded
);

  seq_state_e         state_q, state_d;
  logic [INSTR_W-1:0] ram_q [PROG_DEPTH];
  logic [ADDR_W-1:0]  wptr_q;
  logic               loaded_q;
  logic               skip_bp_q;
  logic               ld_ready_q, cpu_n_reset_q, cpu_clk_en_q;
  logic               ld_ready_d, cpu_n_reset_d, cpu_clk_en_d;
  logic               accept_c, last_accept_c, bp_hit_c;
  logic               tc_c, div_clear_c, div_enable_c;
  logic               pulse_c;

  assign accept_c      = (state_q == ST_LOAD) && ld_ready_q && ld_valid;
  assign last_accept_c = accept_c && (wptr_q == ADDR_W'(PROG_DEPTH - 1));
  assign bp_hit_c      = bp_en && (cpu_addr == bp_addr);

  // Divider restarts on every RUN entry and only advances while staying in RUN.
  assign div_clear_c  = (state_q != ST_RUN);
  assign div_enable_c = (state_d == ST_RUN);

  tick_divider #(
    .CLK_DIV (CLK_DIV)
  ) u_tick_divider (
    .clk     (clk),
    .n_reset (n_reset),
    .clear   (div_clear_c),
    .enable  (div_enable_c),
    .tc_c    (tc_c)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state; pulse_c requests a CPU clock-enable pulse in the next cycle.
  always_comb begin
    state_d = state_q;
    pulse_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!cmd_halt) begin
          if (cmd_load) begin
            state_d = ST_LOAD;
          end else if (cmd_run && loaded_q) begin
            state_d = ST_RUN;
            pulse_c = tc_c;
          end
        end
      end
      ST_LOAD: begin
        if (cmd_halt || last_accept_c) begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (cmd_halt) begin
          state_d = ST_HALT;
        end else if (tc_c) begin
          // Stop before the breakpoint instruction executes.
          if (bp_hit_c && !skip_bp_q) begin
            state_d = ST_HALT;
          end else begin
            pulse_c = 1'b1;
          end
        end
      end
      ST_HALT: begin
        if (cmd_halt) begin
          state_d = ST_IDLE;
        end else if (cmd_load) begin
          state_d = ST_LOAD;
        end else if (cmd_step) begin
          pulse_c = 1'b1;
        end else if (cmd_run) begin
          state_d = ST_RUN;
          pulse_c = tc_c;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode from the upcoming state; CPU is held in reset outside RUN/HALT.
  always_comb begin
    ld_ready_d    = (state_d == ST_LOAD);
    cpu_n_reset_d = 1'b1;
    cpu_clk_en_d  = pulse_c;
    if ((state_d == ST_IDLE) || (state_d == ST_LOAD)) begin
      cpu_n_reset_d = 1'b0;
      cpu_clk_en_d  = 1'b1;
    end
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      ld_ready_q    <= 1'b0;
      cpu_n_reset_q <= 1'b0;
      cpu_clk_en_q  <= 1'b1;
    end else begin
      ld_ready_q    <= ld_ready_d;
      cpu_n_reset_q <= cpu_n_reset_d;
      cpu_clk_en_q  <= cpu_clk_en_d;
    end
  end

  // Program RAM, write pointer and image-complete flag.
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      for (int i = 0; i < int'(PROG_DEPTH); i++) begin
        ram_q[i] <= '0;
      end
      wptr_q   <= '0;
      loaded_q <= 1'b0;
    end else if ((state_q != ST_LOAD) && (state_d == ST_LOAD)) begin
      wptr_q   <= '0;
      loaded_q <= 1'b0;
    end else begin
      if (accept_c) begin
        ram_q[wptr_q] <= ld_data;
        wptr_q        <= wptr_q + ADDR_W'(1);
      end
      if ((state_q == ST_LOAD) && cmd_halt) begin
        loaded_q <= 1'b0;
      end else if (last_accept_c) begin
        loaded_q <= 1'b1;
      end
    end
  end

  // Resuming from HALT lets the first pulse through even at the breakpoint.
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      skip_bp_q <= 1'b0;
    end else if ((state_q != ST_RUN) && (state_d == ST_RUN)) begin
      skip_bp_q <= (state_q == ST_HALT) && !tc_c;
    end else if ((state_q == ST_RUN) && tc_c) begin
      skip_bp_q <= 1'b0;
    end
  end

  assign cpu_data    = ram_q[cpu_addr];
  assign ld_ready    = ld_ready_q;
  assign cpu_n_reset = cpu_n_reset_q;
  assign cpu_clk_en  = cpu_clk_en_q;
  assign state       = state_q;
  assign loaded      = loaded_q;

endmodule

// File: tb/tb_prog_sequencer.sv
// Self-checking bench for prog_sequencer with a stand-in CPU instruction pointer.
module tb_prog_sequencer;

  localparam int unsigned CLK_DIV = 4;

  logic       clk = 1'b0;
  logic       n_reset;
  logic       ld_valid;
  logic [7:0] ld_data;
  logic       ld_ready;
  logic       cmd_load, cmd_run, cmd_step, cmd_halt;
  logic       bp_en;
  logic [3:0] bp_addr;
  logic [3:0] cpu_addr;
  logic [7:0] cpu_data;
  logic       cpu_n_reset;
  logic       cpu_clk_en;
  logic [1:0] state;
  logic       loaded;

  // Stand-in CPU: instruction pointer advances on each enabled clock.
  logic [3:0] ip = 4'd0;
  logic       peek_en = 1'b0;
  logic [3:0] peek_addr = 4'd0;
  assign cpu_addr = peek_en ? peek_addr : ip;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (cpu_n_reset !== 1'b1) ip <= 4'd0;
    else if (cpu_clk_en === 1'b1) ip <= ip + 4'd1;
  end

  prog_sequencer #(.CLK_DIV(CLK_DIV)) dut (
    .clk         (clk),
    .n_reset     (n_reset),
    .ld_valid    (ld_valid),
    .ld_data     (ld_data),
    .ld_ready    (ld_ready),
    .cmd_load    (cmd_load),
    .cmd_run     (cmd_run),
    .cmd_step    (cmd_step),
    .cmd_halt    (cmd_halt),
    .bp_en       (bp_en),
    .bp_addr     (bp_addr),
    .cpu_addr    (cpu_addr),
    .cpu_data    (cpu_data),
    .cpu_n_reset (cpu_n_reset),
    .cpu_clk_en  (cpu_clk_en),
    .state       (state),
    .loaded      (loaded)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h time=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] prog(input int i);
    case (i)
      0:       return 8'h31;
      1:       return 8'h01;
      default: return 8'(32'h40 + i);
    endcase
  endfunction

  // Behavioural model: tracks cycles since RUN entry and derives pulses by modulo.
  int         m_state = 0;
  bit         m_loaded, m_skip, m_en, m_nrst, m_rdy;
  logic [7:0] m_mem [16];
  int         m_wptr, m_n;
  bit         m_valid = 1'b0;
  int         ns;
  bit         pulse, acc;

  always @(posedge clk) begin
    if (!n_reset) begin
      m_state = 0; m_loaded = 0; m_wptr = 0; m_n = 0; m_skip = 0;
      for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
      m_en = 1; m_nrst = 0; m_rdy = 0;
      m_valid = 1'b1;
    end else begin
      ns = m_state;
      pulse = 0;
      acc = (m_state == 1) && m_rdy && ld_valid;
      if (acc) begin
        m_mem[m_wptr] = ld_data;
        m_wptr++;
      end
      case (m_state)
        0: if (!cmd_halt) begin
             if (cmd_load) begin ns = 1; m_wptr = 0; m_loaded = 0; end
             else if (cmd_run && m_loaded) begin
               ns = 2; m_n = 1; pulse = ((1 % CLK_DIV) == 0); m_skip = 0;
             end
           end
        1: if (cmd_halt) begin ns = 0; m_loaded = 0; end
           else if (acc && m_wptr == 16) begin ns = 0; m_loaded = 1; end
        2: if (cmd_halt) ns = 3;
           else begin
             m_n++;
             if ((m_n % CLK_DIV) == 0) begin
               if (bp_en && cpu_addr == bp_addr && !m_skip) ns = 3;
               else begin pulse = 1; m_skip = 0; end
             end
           end
        default: if (cmd_halt) ns = 0;
           else if (cmd_load) begin ns = 1; m_wptr = 0; m_loaded = 0; end
           else if (cmd_step) pulse = 1;
           else if (cmd_run) begin
             ns = 2; m_n = 1; pulse = ((1 % CLK_DIV) == 0); m_skip = !pulse;
           end
      endcase
      m_wptr = m_wptr % 16;
      m_state = ns;
      m_nrst = (ns >= 2);
      m_en = (ns < 2) ? 1'b1 : pulse;
      m_rdy = (ns == 1);
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_valid) begin
      check("state", 32'(state), 32'(m_state));
      check("loaded", 32'(loaded), 32'(m_loaded));
      check("ld_ready", 32'(ld_ready), 32'(m_rdy));
      check("cpu_n_reset", 32'(cpu_n_reset), 32'(m_nrst));
      check("cpu_clk_en", 32'(cpu_clk_en), 32'(m_en));
      check("cpu_data", 32'(cpu_data), 32'(m_mem[cpu_addr]));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic pulse_cmd(input int which);
    case (which)
      0: cmd_load = 1'b1;
      1: cmd_run  = 1'b1;
      2: cmd_step = 1'b1;
      default: cmd_halt = 1'b1;
    endcase
    tick();
    cmd_load = 1'b0; cmd_run = 1'b0; cmd_step = 1'b0; cmd_halt = 1'b0;
  endtask

  task automatic load_bytes(input int n, output int rdy_cnt);
    rdy_cnt = 0;
    pulse_cmd(0);
    for (int i = 0; i < n; i++) begin
      if (ld_ready === 1'b1) rdy_cnt++;
      ld_valid = 1'b1;
      ld_data  = prog(i);
      tick();
    end
    ld_valid = 1'b0;
    ld_data  = 8'h00;
  endtask

  task automatic peek(input logic [3:0] a, input logic [7:0] exp, input string name);
    peek_en = 1'b1;
    peek_addr = a;
    #1;
    check(name, 32'(cpu_data), 32'(exp));
    peek_en = 1'b0;
    #1;
  endtask

  task automatic wait_halt(input string name);
    int k;
    k = 0;
    while (state !== 2'd3 && k < 60) begin
      tick();
      k++;
    end
    check(name, 32'(state), 32'd3);
  endtask

  int          rdy_cnt;
  logic [11:0] exp_pulse;

  initial begin
    n_reset = 1'b0; ld_valid = 1'b0; ld_data = 8'h00;
    cmd_load = 1'b0; cmd_run = 1'b0; cmd_step = 1'b0; cmd_halt = 1'b0;
    bp_en = 1'b0; bp_addr = 4'd0;
    tick(); tick();
    check("rst_state", 32'(state), 32'd0);
    check("rst_loaded", 32'(loaded), 32'd0);
    check("rst_ld_ready", 32'(ld_ready), 32'd0);
    check("rst_cpu_n_reset", 32'(cpu_n_reset), 32'd0);
    check("rst_cpu_clk_en", 32'(cpu_clk_en), 32'd1);
    n_reset = 1'b1;
    tick();

    // Partial load with an idle beat, then abort.
    pulse_cmd(0);
    check("partial_rdy", 32'(ld_ready), 32'd1);
    for (int i = 0; i < 5; i++) begin
      ld_valid = 1'b1; ld_data = prog(i); tick();
    end
    ld_valid = 1'b0; ld_data = 8'hEE; tick();
    pulse_cmd(3);
    check("partial_state", 32'(state), 32'd0);
    check("partial_loaded", 32'(loaded), 32'd0);
    pulse_cmd(1);
    tick();
    check("partial_run_state", 32'(state), 32'd0);
    check("partial_run_nrst", 32'(cpu_n_reset), 32'd0);
    peek(4'd4, 8'h44, "partial_ram4");
    peek(4'd5, 8'h00, "partial_ram5");

    // Full image.
    load_bytes(16, rdy_cnt);
    check("full_rdy_cycles", 32'(rdy_cnt), 32'd16);
    check("full_rdy_drop", 32'(ld_ready), 32'd0);
    check("full_state", 32'(state), 32'd0);
    check("full_loaded", 32'(loaded), 32'd1);
    peek(4'd15, 8'h4F, "full_ram15");
    peek(4'd0, 8'h31, "full_ram0");

    // Free run: pulses at cycles 4, 8, 12 after the run edge.
    exp_pulse = 12'b1000_1000_1000;
    pulse_cmd(1);
    check("run_c1_nrst", 32'(cpu_n_reset), 32'd1);
    for (int n = 1; n <= 12; n++) begin
      check("run_pulse", 32'(cpu_clk_en), 32'(exp_pulse[n-1]));
      if (n < 12) tick();
    end
    pulse_cmd(3);
    check("halt_state", 32'(state), 32'd3);
    check("halt_en", 32'(cpu_clk_en), 32'd0);
    pulse_cmd(3);
    check("halt_idle", 32'(state), 32'd0);

    // Breakpoint at 3, step past it, resume.
    bp_en = 1'b1; bp_addr = 4'd3;
    pulse_cmd(1);
    wait_halt("bp_halt_state");
    check("bp_halt_ip", 32'(cpu_addr), 32'd3);
    pulse_cmd(2);
    check("step_en", 32'(cpu_clk_en), 32'd1);
    check("step_state", 32'(state), 32'd3);
    tick();
    check("step_ip", 32'(cpu_addr), 32'd4);
    check("step_en_off", 32'(cpu_clk_en), 32'd0);
    pulse_cmd(1);
    for (int n = 0; n < 23; n++) tick();
    check("resume_state", 32'(state), 32'd2);
    check("resume_ip", 32'(cpu_addr), 32'd9);

    // Resume directly from the breakpoint: first pulse executes ip 3.
    pulse_cmd(3);
    pulse_cmd(3);
    pulse_cmd(1);
    wait_halt("bp2_halt_state");
    check("bp2_halt_ip", 32'(cpu_addr), 32'd3);
    pulse_cmd(1);
    for (int n = 0; n < 4; n++) tick();
    check("bp2_resume_state", 32'(state), 32'd2);
    check("bp2_resume_ip", 32'(cpu_addr), 32'd4);

    // Simultaneous commands in HALT.
    pulse_cmd(3);
    cmd_run = 1'b1; cmd_halt = 1'b1; tick();
    cmd_run = 1'b0; cmd_halt = 1'b0;
    check("run_halt_not_run", 32'(state == 2'd2), 32'd0);
    pulse_cmd(1);
    pulse_cmd(3);
    check("pre_ls_state", 32'(state), 32'd3);
    cmd_load = 1'b1; cmd_step = 1'b1; tick();
    cmd_load = 1'b0; cmd_step = 1'b0;
    check("load_step_state", 32'(state), 32'd1);
    check("load_step_nrst", 32'(cpu_n_reset), 32'd0);
    pulse_cmd(3);
    check("load_abort_loaded", 32'(loaded), 32'd0);

    // Reset during RUN.
    load_bytes(16, rdy_cnt);
    pulse_cmd(1);
    for (int n = 0; n < 5; n++) tick();
    n_reset = 1'b0;
    tick();
    check("mid_rst_state", 32'(state), 32'd0);
    check("mid_rst_loaded", 32'(loaded), 32'd0);
    check("mid_rst_nrst", 32'(cpu_n_reset), 32'd0);
    peek(4'd0, 8'h00, "mid_rst_ram0");
    n_reset = 1'b1;
    tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
